vga_source_mux: RTL and testbench

Frame-aligned, glitch-free selector that routes one of NUM_SRC VGA timing/colour sources to the board VGA pins.
- Debounces a board switch (or switch bank) selection.
- Changes source only at the active source's vsync leading edge.
- Forces black for a configurable number of frames after each change so the monitor can re-lock.
- Sits at top level, between the VGA generators and the pins. Replaces the hard-wired two-way switch selection.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_sel_debounce.sv | 59 +++++
 rtl/vga_source_mux.sv | 191 +++++++++++++++++++
 tb/tb_vga_source_mux.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA source selector.
package vga_pkg;

  localparam int COLOR_W_DEFAULT = 4;

  typedef struct packed {
    logic [COLOR_W_DEFAULT-1:0] red;
    logic [COLOR_W_DEFAULT-1:0] green;
    logic [COLOR_W_DEFAULT-1:0] blue;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    BLANK   = 2'd2
  } mux_state_t;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/vga_sel_debounce.sv
// Two-flop synchroniser plus stability counter for the source-select switches.
// Out-of-range selections are never accepted; sel_stable holds its last legal value.
module vga_sel_debounce import vga_pkg::*; #(
  parameter  int NUM_SRC         = 2,
  parameter  int DEBOUNCE_CYCLES = 250000,
  localparam int SEL_W           = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel_raw,
  output logic [SEL_W-1:0] sel_stable
);

  localparam int               CNT_W     = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int               SEL_W1    = SEL_W + 1;
  localparam logic [SEL_W:0]   SEL_LIMIT = SEL_W1'(NUM_SRC);

  logic [SEL_W-1:0] sync1_q, sync2_q;
  logic [SEL_W-1:0] cand_q, cand_d;
  logic [SEL_W-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else begin
      if (cnt_q != CNT_LAST) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_q == CNT_LAST && {1'b0, cand_q} < SEL_LIMIT) begin
        stable_d = cand_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= sel_raw;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign sel_stable = stable_q;

endmodule

// File: rtl/vga_source_mux.sv
// Frame-aligned VGA source selector: switches only on the active source's vsync
// leading edge, then blanks RGB for BLANK_FRAMES frames. Optional vsync watchdog: VGA_MUX_TIMEOUT_EN.
module vga_source_mux import vga_pkg::*; #(
  parameter  int NUM_SRC         = 2,
  parameter  int COLOR_W         = COLOR_W_DEFAULT,
  parameter  int DEBOUNCE_CYCLES = 250000,
  parameter  int BLANK_FRAMES    = 2,
  parameter  int TIMEOUT_CYCLES  = 1000000,
  localparam int SEL_W           = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SEL_W-1:0]           sel_raw,
  input  logic [NUM_SRC*COLOR_W-1:0] src_red,
  input  logic [NUM_SRC*COLOR_W-1:0] src_green,
  input  logic [NUM_SRC*COLOR_W-1:0] src_blue,
  input  logic [NUM_SRC-1:0]         src_h_sync,
  input  logic [NUM_SRC-1:0]         src_v_sync,
  input  logic [NUM_SRC-1:0]         src_de,
  output logic [COLOR_W-1:0]         vga_red,
  output logic [COLOR_W-1:0]         vga_green,
  output logic [COLOR_W-1:0]         vga_blue,
  output logic                       h_sync,
  output logic                       v_sync,
  output logic [SEL_W-1:0]           active_sel,
  output logic                       switching
);

  localparam int               BLK_W      = clog2_min1(BLANK_FRAMES);
  localparam logic [BLK_W-1:0] BLANK_LAST = BLK_W'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

  if (NUM_SRC < 2 || COLOR_W < 1 || DEBOUNCE_CYCLES < 1 || BLANK_FRAMES < 0 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("vga_source_mux: illegal parameter value");
  end

  logic [SEL_W-1:0]   sel_stable;
  logic [NUM_SRC-1:0] vs_prev_q;
  logic [NUM_SRC-1:0] vs_fall;
  logic               vs_edge;
  logic               wd_fire;

  mux_state_t         state_q, state_d;
  logic [SEL_W-1:0]   active_sel_q, active_sel_d;
  logic [SEL_W-1:0]   pending_q, pending_d;
  logic [BLK_W-1:0]   blank_cnt_q, blank_cnt_d;
  logic               switching_q, switching_d;

  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic               hs_q, hs_d, vs_q, vs_d;

  logic [COLOR_W-1:0] red_arr   [NUM_SRC];
  logic [COLOR_W-1:0] green_arr [NUM_SRC];
  logic [COLOR_W-1:0] blue_arr  [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign red_arr[i]   = src_red[i*COLOR_W +: COLOR_W];
    assign green_arr[i] = src_green[i*COLOR_W +: COLOR_W];
    assign blue_arr[i]  = src_blue[i*COLOR_W +: COLOR_W];
  end

  vga_sel_debounce #(
    .NUM_SRC         (NUM_SRC),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel_raw    (sel_raw),
    .sel_stable (sel_stable)
  );

  // Edges are tracked on every source so the new source's first frame is seen right after a switch.
  assign vs_fall = vs_prev_q & ~src_v_sync;
  assign vs_edge = vs_fall[active_sel_q] | wd_fire;

  always_comb begin
    state_d      = state_q;
    active_sel_d = active_sel_q;
    pending_d    = pending_q;
    blank_cnt_d  = blank_cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_stable != active_sel_q) begin
          pending_d = sel_stable;
          state_d   = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (sel_stable != pending_q) begin
          pending_d = sel_stable;
        end
        if (sel_stable == active_sel_q) begin
          state_d = IDLE;
        end else if (vs_edge) begin
          active_sel_d = pending_d;
          blank_cnt_d  = '0;
          state_d      = (BLANK_FRAMES == 0) ? IDLE : BLANK;
        end
      end
      BLANK: begin
        if (vs_edge) begin
          if (blank_cnt_q == BLANK_LAST) begin
            state_d = IDLE;
          end else begin
            blank_cnt_d = blank_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef VGA_MUX_TIMEOUT_EN
  localparam int            WD_W    = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // A dead source never produces an edge; the watchdog stands in for it.
  assign wd_fire = (state_q != IDLE) && (wd_q == WD_LAST);

  always_comb begin
    wd_d = wd_q + 1'b1;
    if (state_q == IDLE || state_d != state_q || (state_q == BLANK && vs_edge)) begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  // Mux on the next-state select so outputs and active_sel always refer to the same source.
  always_comb begin
    hs_d        = src_h_sync[active_sel_d];
    vs_d        = src_v_sync[active_sel_d];
    red_d       = '0;
    green_d     = '0;
    blue_d      = '0;
    switching_d = (state_q != IDLE);
    if (src_de[active_sel_d] && state_d != BLANK) begin
      red_d   = red_arr[active_sel_d];
      green_d = green_arr[active_sel_d];
      blue_d  = blue_arr[active_sel_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      active_sel_q <= '0;
      pending_q    <= '0;
      blank_cnt_q  <= '0;
      switching_q  <= 1'b0;
      vs_prev_q    <= '0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      active_sel_q <= active_sel_d;
      pending_q    <= pending_d;
      blank_cnt_q  <= blank_cnt_d;
      switching_q  <= switching_d;
      vs_prev_q    <= src_v_sync;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
    end
  end

  assign vga_red    = red_q;
  assign vga_green  = green_q;
  assign vga_blue   = blue_q;
  assign h_sync     = hs_q;
  assign v_sync     = vs_q;
  assign active_sel = active_sel_q;
  assign switching  = switching_q;

endmodule

// File: tb/tb_vga_source_mux.sv
// Scoreboard bench for vga_source_mux: three synthetic VGA sources, a frame-level
// reference model pushing expected outputs each cycle, and a monitor popping them.
module tb_vga_source_mux;

  localparam int NS = 3;
  localparam int CW = 4;
  localparam int DB = 4;
  localparam int BF = 2;
  localparam int TO = 50;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [SW-1:0]     sel_raw = '0;
  logic [NS*CW-1:0]  src_red, src_green, src_blue;
  logic [NS-1:0]     src_h_sync, src_v_sync, src_de;
  logic [CW-1:0]     vga_red, vga_green, vga_blue;
  logic              h_sync, v_sync, switching;
  logic [SW-1:0]     active_sel;

  always #5 clk = ~clk;

  vga_source_mux #(
    .NUM_SRC(NS), .COLOR_W(CW), .DEBOUNCE_CYCLES(DB), .BLANK_FRAMES(BF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sel_raw(sel_raw),
    .src_red(src_red), .src_green(src_green), .src_blue(src_blue),
    .src_h_sync(src_h_sync), .src_v_sync(src_v_sync), .src_de(src_de),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .h_sync(h_sync), .v_sync(v_sync), .active_sel(active_sel), .switching(switching)
  );

  // ---------------- sources ----------------
  int period [NS] = '{200, 300, 400};
  int pos    [NS];
  bit hold0 = 1'b0;

  task automatic drive_sources();
    for (int k = 0; k < NS; k++) begin
      src_v_sync[k] = (hold0 && k == 0) ? 1'b1 : (pos[k] >= 4);
      src_h_sync[k] = (pos[k] % 20) >= 3;
      src_de[k]     = (pos[k] >= 20) && ((pos[k] % 20) >= 5);
      src_red[k*CW +: CW]   = CW'($urandom);
      src_green[k*CW +: CW] = CW'($urandom);
      src_blue[k*CW +: CW]  = CW'($urandom);
    end
  endtask

  initial begin
    for (int k = 0; k < NS; k++) pos[k] = k * 37;
    drive_sources();
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NS; k++) pos[k] = (pos[k] + 1) % period[k];
      drive_sources();
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [CW-1:0] r, g, b;
    logic          hs, vs;
    logic [SW-1:0] act;
    logic          sw;
  } exp_t;

  exp_t exp_q[$];

  int m_mode;    // 0 idle, 1 waiting for edge, 2 blanking
  int m_active, m_pend, m_stable, m_frames, m_wd;
  bit m_prev [NS];
  int raw_dly[$];
  int last_val, run;

  task automatic model_reset();
    m_mode = 0; m_active = 0; m_pend = 0; m_stable = 0; m_frames = 0; m_wd = 0;
    for (int k = 0; k < NS; k++) m_prev[k] = 1'b0;
    raw_dly = '{0, 0};
    last_val = 0;
    run = 1;
  endtask

  task automatic model_step();
    bit   fall [NS];
    bit   ev, fire;
    int   na, nm, val;
    exp_t e;
    for (int k = 0; k < NS; k++) fall[k] = m_prev[k] && !src_v_sync[k];
    fire = 1'b0;
`ifdef VGA_MUX_TIMEOUT_EN
    fire = (m_mode != 0) && (m_wd == TO - 1);
`endif
    ev = fall[m_active] || fire;
    na = m_active;
    nm = m_mode;
    case (m_mode)
      0: if (m_stable != m_active) begin m_pend = m_stable; nm = 1; end
      1: begin
        m_pend = m_stable;
        if (m_stable == m_active) nm = 0;
        else if (ev) begin na = m_pend; m_frames = 0; nm = (BF == 0) ? 0 : 2; end
      end
      default: if (ev) begin m_frames++; if (m_frames == BF) nm = 0; end
    endcase
    e.act = SW'(na);
    e.hs  = src_h_sync[na];
    e.vs  = src_v_sync[na];
    e.sw  = (m_mode != 0);
    if (nm == 2 || !src_de[na]) begin
      e.r = '0; e.g = '0; e.b = '0;
    end else begin
      e.r = src_red[na*CW +: CW];
      e.g = src_green[na*CW +: CW];
      e.b = src_blue[na*CW +: CW];
    end
`ifdef VGA_MUX_TIMEOUT_EN
    if (m_mode == 0 || nm != m_mode || (m_mode == 2 && ev)) m_wd = 0;
    else m_wd++;
`endif
    exp_q.push_back(e);
    m_active = na;
    m_mode   = nm;
    for (int k = 0; k < NS; k++) m_prev[k] = src_v_sync[k];
    // selection is accepted after 2 sync cycles once it has been seen 5 times in a row
    raw_dly.push_back(int'(sel_raw));
    val = raw_dly.pop_front();
    if (val == last_val) run++;
    else begin last_val = val; run = 1; end
    if (run >= DB + 1 && val < NS) m_stable = val;
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // ---------------- monitor ----------------
  int total = 0;
  int bad = 0;

  always @(negedge clk) begin
    exp_t got, want;
    got.r = vga_red; got.g = vga_green; got.b = vga_blue;
    got.hs = h_sync; got.vs = v_sync; got.act = active_sel; got.sw = switching;
    if (!rst_n) begin
      exp_q.delete();
      want = '{r: '0, g: '0, b: '0, hs: 1'b1, vs: 1'b1, act: '0, sw: 1'b0};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset_state t=%0t got=%h want=%h", $time, got, want);
      end
    end else if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL scoreboard t=%0t got=%h want=%h (r,g,b,hs,vs,act,sw)", $time, got, want);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic wait_act(input int v, input int budget, input string nm);
    int n = 0;
    while (int'(active_sel) != v && n < budget) begin step(1); n++; end
    check(nm, int'(active_sel), v);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (switching !== 1'b0 && n < budget) begin step(1); n++; end
    check(nm, int'(switching), 0);
  endtask

  task automatic align_src0(input int target);
    int n = 0;
    while (pos[0] != target && n < 500) begin step(1); n++; end
    check("align_src0", int'(n < 500), 1);
  endtask

  initial begin
    bit saw_sw, moved;
    rst_n = 1'b0;
    sel_raw = '0;
    step(3);
    rst_n = 1'b1;
    step(300);

    // bounce 0->1->0->1 then hold
    sel_raw = 2'd1; step(2);
    sel_raw = 2'd0; step(2);
    sel_raw = 2'd1;
    wait_act(1, 600, "bounce_switch_to_1");
    wait_idle(1500, "bounce_blank_done");

    // switch to source 2
    step(20);
    sel_raw = 2'd2;
    wait_act(2, 600, "switch_to_2");
    check("switching_in_blank", int'(switching), 1);
    wait_idle(2000, "blank_2_done");
    step(57);

    // reset mid-frame while source 2 is routed
    rst_n = 1'b0;
    sel_raw = 2'd0;
    #1;
    check("async_rst_act", int'(active_sel), 0);
    check("async_rst_hs", int'(h_sync), 1);
    check("async_rst_vs", int'(v_sync), 1);
    check("async_rst_rgb", int'({vga_red, vga_green, vga_blue}), 0);
    step(3);
    rst_n = 1'b1;
    step(50);

    // revert during WAIT_VS
    align_src0(10);
    sel_raw = 2'd1; step(10);
    sel_raw = 2'd0;
    saw_sw = 1'b0; moved = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (switching) saw_sw = 1'b1;
      if (active_sel != 0) moved = 1'b1;
    end
    check("revert_saw_wait", int'(saw_sw), 1);
    check("revert_no_move", int'(moved), 0);
    check("revert_idle", int'(switching), 0);

    // out-of-range selection
    sel_raw = 2'd3;
    saw_sw = 1'b0; moved = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (switching) saw_sw = 1'b1;
      if (active_sel != 0) moved = 1'b1;
    end
    check("oor_no_switch", int'(saw_sw), 0);
    check("oor_no_move", int'(moved), 0);
    sel_raw = 2'd0;
    step(20);

`ifdef VGA_MUX_TIMEOUT_EN
    // dead source 0: watchdog forces the switch
    hold0 = 1'b1;
    step(10);
    sel_raw = 2'd1;
    begin
      int n = 0;
      while (switching !== 1'b1 && n < 100) begin step(1); n++; end
      check("wd_enter_wait", int'(switching), 1);
      n = 0;
      while (active_sel != 1 && n < 200) begin step(1); n++; end
      check("wd_switch", int'(active_sel), 1);
      check("wd_latency", n, TO - 1);
    end
    hold0 = 1'b0;
    wait_idle(2000, "wd_blank_done");
`endif

    // randomized selection activity
    for (int i = 0; i < 20; i++) begin
      sel_raw = SW'($urandom_range(0, 3));
      step($urandom_range(1, 500));
    end
    sel_raw = 2'd0;
    step(1200);
    wait_idle(2000, "final_idle");
    check("final_active", int'(active_sel), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
